tage_update_queue: RTL and testbench

// - In-order queue of in-flight TAGE predictions, between fetch-side prediction and back-end branch resolution.
// - Each prediction (PC index + predicted direction) is enqueued at predict time.
// - Each resolution pops the oldest entry and drives the predictor's update inputs (outcome, correct flag, index).
// - Also keeps a saturating mispredict counter and a sticky underflow error flag.

---
 rtl/tage_pkg.sv | 12 +
 rtl/tage_update_queue_if.sv | 28 ++
 rtl/tage_uq_fifo.sv | 55 +++++
 rtl/tage_update_queue.sv | 74 +++++++
 tb/tb_tage_update_queue.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/tage_pkg.sv
// Shared types for the TAGE update queue: queued prediction entry and default sizes.
package tage_pkg;

  localparam int UQ_DEPTH_DEFAULT = 8;
  localparam int UQ_IDX_W         = 32;

  typedef struct packed {
    logic [UQ_IDX_W-1:0] idx;
    logic                taken;
  } tage_uq_entry_t;

endpackage

// File: rtl/tage_update_queue_if.sv
// Prediction enqueue, resolution and predictor-update bundle of the TAGE update queue.
interface tage_update_queue_if #(
  parameter int IDX_W = 32
);

  logic             pred_valid_i;
  logic [IDX_W-1:0] pred_idx_i;
  logic             pred_taken_i;
  logic             pred_ready_o;
  logic             res_valid_i;
  logic             res_taken_i;
  logic             flush_i;
  logic             upd_valid_o;
  logic [IDX_W-1:0] upd_idx_o;
  logic             upd_br_result_o;
  logic             upd_correct_o;

  modport master (
    output pred_valid_i, pred_idx_i, pred_taken_i, res_valid_i, res_taken_i, flush_i,
    input  pred_ready_o, upd_valid_o, upd_idx_o, upd_br_result_o, upd_correct_o
  );

  modport slave (
    input  pred_valid_i, pred_idx_i, pred_taken_i, res_valid_i, res_taken_i, flush_i,
    output pred_ready_o, upd_valid_o, upd_idx_o, upd_br_result_o, upd_correct_o
  );

endinterface

// File: rtl/tage_uq_fifo.sv
// Circular entry store with head/tail/count; push ignored when full, pop ignored when empty.
// Head read is combinational; clear wins over push and drops everything after a same-cycle pop.
module tage_uq_fifo
  import tage_pkg::*;
#(
  parameter int DEPTH = UQ_DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  tage_uq_entry_t           push_dat_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output tage_uq_entry_t           head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  tage_uq_entry_t   mem [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem[head_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[tail_q] <= push_dat_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) tail_q <= tail_q + 1'b1;
      if (pop_ok)  head_q <= head_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tage_update_queue.sv
// In-order queue of in-flight TAGE predictions; each resolution pops the head and emits a
// registered 1-cycle update beat (no backpressure). Producer stalls on pred_ready_o when full.
module tage_update_queue
  import tage_pkg::*;
#(
  parameter int DEPTH = UQ_DEPTH_DEFAULT,
  parameter int IDX_W = UQ_IDX_W,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  tage_update_queue_if.slave     uq,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [CNT_W-1:0]       mispred_cnt_o,
  output logic                   underflow_o
);

  tage_uq_entry_t   head, push_dat;
  logic             fifo_full, fifo_empty;
  logic             deq, hit;
  logic             upd_valid_q, upd_br_q, upd_correct_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic [CNT_W-1:0] mispred_q;
  logic             underflow_q;

  assign push_dat = '{idx: uq.pred_idx_i, taken: uq.pred_taken_i};
  assign deq      = uq.res_valid_i && !fifo_empty;
  assign hit      = (head.taken == uq.res_taken_i);

  tage_uq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (uq.pred_valid_i),
    .push_dat_i (push_dat),
    .pop_i      (deq),
    .clear_i    (uq.flush_i),
    .head_o     (head),
    .count_o    (count_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      upd_valid_q   <= 1'b0;
      upd_idx_q     <= '0;
      upd_br_q      <= 1'b0;
      upd_correct_q <= 1'b0;
      mispred_q     <= '0;
      underflow_q   <= 1'b0;
    end else begin
      upd_valid_q <= deq;
      if (deq) begin
        upd_idx_q     <= head.idx;
        upd_br_q      <= uq.res_taken_i;
        upd_correct_q <= hit;
      end else begin
        // Idle beats report "correct" so the predictor never allocates on them.
        upd_correct_q <= 1'b1;
      end
      if (deq && !hit && (mispred_q != '1)) mispred_q <= mispred_q + 1'b1;
      if (uq.res_valid_i && fifo_empty) underflow_q <= 1'b1;
    end
  end

  assign uq.pred_ready_o    = !fifo_full;
  assign uq.upd_valid_o     = upd_valid_q;
  assign uq.upd_idx_o       = upd_idx_q;
  assign uq.upd_br_result_o = upd_br_q;
  assign uq.upd_correct_o   = upd_correct_q;
  assign mispred_cnt_o      = mispred_q;
  assign underflow_o        = underflow_q;

endmodule

// File: tb/tb_tage_update_queue.sv
// Directed bench for tage_update_queue with a queue-based reference model checked every cycle.
module tb_tage_update_queue;
  import tage_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDX_W = 32;
  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count;
  logic [15:0] mispred;
  logic       underflow;

  int n_tests = 0;
  int n_fail  = 0;

  tage_update_queue_if #(.IDX_W(IDX_W)) uq ();

  tage_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .uq            (uq),
    .count_o       (count),
    .mispred_cnt_o (mispred),
    .underflow_o   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus counters, advanced from the inputs at each edge.
  tage_uq_entry_t q[$];
  bit          chk_en = 0;
  bit          m_vld, m_br, m_corr, m_uf;
  logic [31:0] m_idx;
  int          m_mis;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        m_vld = 0; m_idx = 0; m_br = 0; m_corr = 0; m_uf = 0; m_mis = 0;
        chk_en = 1;
      end else begin
        bit was_full, was_empty;
        tage_uq_entry_t e;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (uq.res_valid_i && !was_empty) begin
          e      = q.pop_front();
          m_vld  = 1;
          m_idx  = e.idx;
          m_br   = uq.res_taken_i;
          m_corr = (e.taken == uq.res_taken_i);
          if (!m_corr && m_mis < 65535) m_mis++;
        end else begin
          m_vld  = 0;
          m_corr = 1;
        end
        if (uq.res_valid_i && was_empty) m_uf = 1;
        if (uq.flush_i) q.delete();
        else if (uq.pred_valid_i && !was_full) q.push_back('{idx: uq.pred_idx_i, taken: uq.pred_taken_i});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_ready", 32'(uq.pred_ready_o), 32'(q.size() != DEPTH));
      chk("m_upd_valid", 32'(uq.upd_valid_o), 32'(m_vld));
      chk("m_upd_correct", 32'(uq.upd_correct_o), 32'(m_corr));
      if (m_vld) begin
        chk("m_upd_idx", uq.upd_idx_o, m_idx);
        chk("m_upd_br", 32'(uq.upd_br_result_o), 32'(m_br));
      end
      chk("m_mispred", 32'(mispred), 32'(m_mis));
      chk("m_underflow", 32'(underflow), 32'(m_uf));
    end
  end

  task automatic cyc(input logic pv, input logic [31:0] pidx, input logic pt,
                     input logic rv, input logic rt, input logic fl);
    uq.pred_valid_i = pv; uq.pred_idx_i = pidx; uq.pred_taken_i = pt;
    uq.res_valid_i  = rv; uq.res_taken_i = rt;  uq.flush_i = fl;
    @(posedge clk); #1;
    uq.pred_valid_i = 0; uq.res_valid_i = 0; uq.flush_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    uq.pred_valid_i = 0; uq.pred_idx_i = 0; uq.pred_taken_i = 0;
    uq.res_valid_i = 0; uq.res_taken_i = 0; uq.flush_i = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_upd_valid", 32'(uq.upd_valid_o), 0);
    chk("rst_mispred", 32'(mispred), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_ready", 32'(uq.pred_ready_o), 1);
    rst_n = 1;

    // Three predictions, all resolved taken.
    cyc(1, 32'h10, 1, 0, 0, 0);
    cyc(1, 32'h20, 0, 0, 0, 0);
    cyc(1, 32'h30, 1, 0, 0, 0);
    chk("t1_count", 32'(count), 3);
    cyc(0, 0, 0, 1, 1, 0);
    chk("t1_v0", 32'(uq.upd_valid_o), 1);
    chk("t1_idx0", uq.upd_idx_o, 32'h10);
    chk("t1_corr0", 32'(uq.upd_correct_o), 1);
    chk("t1_br0", 32'(uq.upd_br_result_o), 1);
    cyc(0, 0, 0, 1, 1, 0);
    chk("t1_idx1", uq.upd_idx_o, 32'h20);
    chk("t1_corr1", 32'(uq.upd_correct_o), 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("t1_idx2", uq.upd_idx_o, 32'h30);
    chk("t1_corr2", 32'(uq.upd_correct_o), 1);
    chk("t1_mispred", 32'(mispred), 1);
    chk("t1_empty", 32'(count), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_idle_v", 32'(uq.upd_valid_o), 0);
    chk("t1_idle_corr", 32'(uq.upd_correct_o), 1);

    // Fill, then attempt a 9th enqueue alongside a resolve.
    for (int i = 0; i < 8; i++) cyc(1, 32'h100 + 32'(i), 1'(i), 0, 0, 0);
    chk("t2_ready", 32'(uq.pred_ready_o), 0);
    chk("t2_count8", 32'(count), 8);
    cyc(1, 32'h999, 0, 1, 0, 0);
    chk("t2_count7", 32'(count), 7);
    chk("t2_idx", uq.upd_idx_o, 32'h100);
    chk("t2_corr", 32'(uq.upd_correct_o), 1);
    for (int i = 1; i < 8; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      chk("t2_drain_idx", uq.upd_idx_o, 32'h100 + 32'(i));
    end
    chk("t2_drained", 32'(count), 0);

    // Underflow: resolve with nothing in flight, including a same-cycle enqueue.
    cyc(0, 0, 0, 1, 0, 0);
    chk("t3_no_upd", 32'(uq.upd_valid_o), 0);
    chk("t3_uf", 32'(underflow), 1);
    cyc(1, 32'h40, 1, 1, 1, 0);
    chk("t3_enq_vis", 32'(count), 1);
    chk("t3_no_upd2", 32'(uq.upd_valid_o), 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("t3_idx", uq.upd_idx_o, 32'h40);
    chk("t3_uf_sticky", 32'(underflow), 1);

    // Flush with a same-cycle resolve and enqueue.
    do_reset();
    chk("t4_uf_clr", 32'(underflow), 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'h50 + 32'(i), 1, 0, 0, 0);
    cyc(1, 32'h77, 0, 1, 0, 1);
    chk("t4_upd", 32'(uq.upd_valid_o), 1);
    chk("t4_idx", uq.upd_idx_o, 32'h50);
    chk("t4_count", 32'(count), 0);
    chk("t4_mispred", 32'(mispred), 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t4_no_upd", 32'(uq.upd_valid_o), 0);
    chk("t4_uf", 32'(underflow), 1);

    // Steady enqueue+dequeue at occupancy 4 across pointer wrap.
    for (int i = 0; i < 4; i++) cyc(1, 32'h200 + 32'(i), 1'(i), 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 32'h204 + 32'(k), 1'(k), 1, 1, 0);
      chk("t5_count", 32'(count), 4);
      chk("t5_idx", uq.upd_idx_o, 32'h200 + 32'(k));
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("t5_drained", 32'(count), 0);

    // Mispredict saturation, then reset in the middle of the burst.
    do_reset();
    cyc(1, 32'hA0, 1, 0, 0, 0);
    for (int n = 0; n < 65540; n++) cyc(1, 32'hA0, 1, 1, 0, 0);
    chk("t6_sat", 32'(mispred), 32'hFFFF);
    cyc(1, 32'hA0, 1, 1, 0, 0);
    chk("t6_hold", 32'(mispred), 32'hFFFF);
    uq.pred_valid_i = 1; uq.pred_idx_i = 32'hA0; uq.pred_taken_i = 1;
    uq.res_valid_i = 1; uq.res_taken_i = 0;
    rst_n = 0;
    @(posedge clk); #1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_mis", 32'(mispred), 0);
    chk("t6_rst_uf", 32'(underflow), 0);
    chk("t6_rst_v", 32'(uq.upd_valid_o), 0);
    chk("t6_rst_idx", uq.upd_idx_o, 0);
    chk("t6_rst_br", 32'(uq.upd_br_result_o), 0);
    chk("t6_rst_corr", 32'(uq.upd_correct_o), 0);
    uq.pred_valid_i = 0; uq.res_valid_i = 0;
    rst_n = 1;
    @(posedge clk); #1;
    chk("t6_ready", 32'(uq.pred_ready_o), 1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
